nora_slv_arbiter: RTL and testbench

NORA_SLV_ARBITER -- requirements
Module: nora_slv_arbiter

---
 rtl/nora_slv_arbiter_if.sv | 38 +++
 rtl/nora_slv_arbiter.sv | 107 ++++++++++
 tb/tb_nora_slv_arbiter.sv | 293 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/nora_slv_arbiter_if.sv
// rtl/nora_slv_arbiter_if.sv - two-master request/ack ports and shared slave bus of the arbiter
interface nora_slv_arbiter_if;
    logic       m0_req;
    logic       m0_rwn;
    logic [3:0] m0_addr;
    logic [7:0] m0_wdata;
    logic [7:0] m0_rdata;
    logic       m0_ack;
    logic       m1_req;
    logic       m1_rwn;
    logic [3:0] m1_addr;
    logic [7:0] m1_wdata;
    logic [7:0] m1_rdata;
    logic       m1_ack;
    logic [3:0] slv_addr;
    logic [7:0] slv_datawr;
    logic       slv_datawr_valid;
    logic       slv_req;
    logic       slv_rwn;
    logic [7:0] slv_datard;

    // The arbiter owns the slave bus and answers both masters.
    modport master (
        input  m0_req, m0_rwn, m0_addr, m0_wdata,
        input  m1_req, m1_rwn, m1_addr, m1_wdata,
        input  slv_datard,
        output m0_rdata, m0_ack, m1_rdata, m1_ack,
        output slv_addr, slv_datawr, slv_datawr_valid, slv_req, slv_rwn
    );

    modport slave (
        output m0_req, m0_rwn, m0_addr, m0_wdata,
        output m1_req, m1_rwn, m1_addr, m1_wdata,
        output slv_datard,
        input  m0_rdata, m0_ack, m1_rdata, m1_ack,
        input  slv_addr, slv_datawr, slv_datawr_valid, slv_req, slv_rwn
    );
endinterface

// File: rtl/nora_slv_arbiter.sv
// rtl/nora_slv_arbiter.sv - two-master arbiter sharing one fixed-latency register slave
module nora_slv_arbiter #(
    parameter int RD_LAT     = 1,
    parameter bit FIXED_PRIO = 1'b0
) (
    input  logic                 clk6x,
    input  logic                 reset,
    nora_slv_arbiter_if.master   bus
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    localparam logic [2:0] WAIT_LOAD = 3'(RD_LAT - 1);

    state_t     state;
    logic [2:0] wait_cnt;
    logic       gnt;
    logic       last_gnt;

    logic       pick;
    logic       any_req;
    logic       sel_rwn;
    logic [3:0] sel_addr;
    logic [7:0] sel_wdata;

    // last_gnt = 1 means m1 was granted last, so m0 wins the next tie.
    always_comb begin
        any_req = bus.m0_req | bus.m1_req;
        if (bus.m0_req && bus.m1_req) begin
            pick = FIXED_PRIO ? 1'b0 : ~last_gnt;
        end else begin
            pick = bus.m1_req;
        end
        sel_rwn   = pick ? bus.m1_rwn   : bus.m0_rwn;
        sel_addr  = pick ? bus.m1_addr  : bus.m0_addr;
        sel_wdata = pick ? bus.m1_wdata : bus.m0_wdata;
    end

    // The slave address/direction/data registers double as the request latch
    // and simply hold between transactions.
    always_ff @(posedge clk6x) begin
        if (reset) begin
            state                <= IDLE;
            wait_cnt             <= 3'd0;
            gnt                  <= 1'b0;
            last_gnt             <= 1'b1;
            bus.slv_req          <= 1'b0;
            bus.slv_datawr_valid <= 1'b0;
            bus.slv_rwn          <= 1'b0;
            bus.slv_addr         <= 4'd0;
            bus.slv_datawr       <= 8'd0;
            bus.m0_ack           <= 1'b0;
            bus.m1_ack           <= 1'b0;
            bus.m0_rdata         <= 8'd0;
            bus.m1_rdata         <= 8'd0;
        end else begin
            bus.m0_ack <= 1'b0;
            bus.m1_ack <= 1'b0;
            case (state)
                IDLE: begin
                    if (any_req) begin
                        gnt                  <= pick;
                        last_gnt             <= pick;
                        bus.slv_addr         <= sel_addr;
                        bus.slv_rwn          <= sel_rwn;
                        bus.slv_datawr       <= sel_wdata;
                        bus.slv_req          <= 1'b1;
                        bus.slv_datawr_valid <= ~sel_rwn;
                        state                <= ISSUE;
                    end
                end
                ISSUE: begin
                    bus.slv_req          <= 1'b0;
                    bus.slv_datawr_valid <= 1'b0;
                    wait_cnt             <= WAIT_LOAD;
                    state                <= WAIT;
                end
                WAIT: begin
                    if (wait_cnt == 3'd0) begin
                        if (bus.slv_rwn) begin
                            if (gnt) begin
                                bus.m1_rdata <= bus.slv_datard;
                            end else begin
                                bus.m0_rdata <= bus.slv_datard;
                            end
                        end
                        if (gnt) begin
                            bus.m1_ack <= 1'b1;
                        end else begin
                            bus.m0_ack <= 1'b1;
                        end
                        state <= DONE;
                    end else begin
                        wait_cnt <= wait_cnt - 3'd1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_nora_slv_arbiter.sv
// tb/tb_nora_slv_arbiter.sv - self-checking bench for nora_slv_arbiter
module tb_nora_slv_arbiter;

    logic clk6x = 1'b0;
    logic reset = 1'b1;
    int   ecount = 0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk6x = ~clk6x;
    always @(posedge clk6x) ecount <= ecount + 1;

    nora_slv_arbiter_if ba ();
    nora_slv_arbiter_if bb ();
    nora_slv_arbiter_if bc ();

    nora_slv_arbiter #(.RD_LAT(1), .FIXED_PRIO(1'b0)) dut_rr (.clk6x(clk6x), .reset(reset), .bus(ba));
    nora_slv_arbiter #(.RD_LAT(1), .FIXED_PRIO(1'b1)) dut_fp (.clk6x(clk6x), .reset(reset), .bus(bb));
    nora_slv_arbiter #(.RD_LAT(3), .FIXED_PRIO(1'b0)) dut_l3 (.clk6x(clk6x), .reset(reset), .bus(bc));

    logic [7:0] mem [16];

    typedef struct {
        bit         m;
        bit         rwn;
        logic [3:0] addr;
        logic [7:0] wd;
        logic [7:0] r0;
        logic [7:0] r1;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Slave models run on the falling edge: ba is a 16-byte register file,
    // bc returns a value that changes every cycle.
    task automatic tick;
        @(negedge clk6x);
        if (ba.slv_req) begin
            if (ba.slv_rwn) ba.slv_datard = mem[ba.slv_addr];
            else            mem[ba.slv_addr] = ba.slv_datawr;
        end
        bc.slv_datard = 8'(ecount);
    endtask

    task automatic do_reset;
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic drive_a(input bit m, input bit req, input bit rwn, input logic [3:0] a, input logic [7:0] d);
        if (m) begin
            ba.m1_req = req; ba.m1_rwn = rwn; ba.m1_addr = a; ba.m1_wdata = d;
        end else begin
            ba.m0_req = req; ba.m0_rwn = rwn; ba.m0_addr = a; ba.m0_wdata = d;
        end
    endtask

    task automatic run_txn(input string nm, input bit m, input bit rwn, input logic [3:0] addr,
                           input logic [7:0] wd, input logic [7:0] r0, input logic [7:0] r1);
        int t_req = -1;
        int t_ack = -1;
        int nreq = 0;
        int bad = 0;
        drive_a(m, 1'b1, rwn, addr, wd);
        for (int c = 1; c <= 12 && t_ack < 0; c++) begin
            tick();
            if (ba.slv_req) begin
                nreq++;
                t_req = c;
                chk({nm, "_addr"}, ba.slv_addr, addr);
                chk({nm, "_rwn"}, ba.slv_rwn, rwn);
                chk({nm, "_wvalid"}, ba.slv_datawr_valid, !rwn);
                chk({nm, "_wdata"}, ba.slv_datawr, wd);
            end
            if (m ? ba.m0_ack : ba.m1_ack) bad++;
            if (m ? ba.m1_ack : ba.m0_ack) begin
                t_ack = c;
                chk({nm, "_rdata0"}, ba.m0_rdata, r0);
                chk({nm, "_rdata1"}, ba.m1_rdata, r1);
            end
        end
        drive_a(m, 1'b0, rwn, addr, wd);
        chk({nm, "_issue_cycle"}, t_req, 1);
        chk({nm, "_issue_count"}, nreq, 1);
        chk({nm, "_ack_cycle"}, t_ack, 3);
        chk({nm, "_other_ack"}, bad, 0);
        tick();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vt [7];
        int   ga [4];
        int   gb [4];
        int   na, nb, tack, nack, nreq, g, a1, a2, bad;
        bit         act [2];
        bit         f_rwn [2];
        logic [3:0] f_addr [2];
        logic [7:0] f_wd [2];
        logic [7:0] mmem [16];
        logic [7:0] exp_rd [2];
        logic [7:0] exp_rdval;
        int   next_eval, tg;
        bit   txn_valid, tm, trwn, last, w, exp_req, is_ack;
        logic [3:0] taddr;
        logic [7:0] twd;

        vt[0] = '{1'b0, 1'b1, 4'h3, 8'h00, 8'hA5, 8'h00};
        vt[1] = '{1'b1, 1'b0, 4'h0, 8'h5C, 8'hA5, 8'h00};
        vt[2] = '{1'b1, 1'b1, 4'h0, 8'h00, 8'hA5, 8'h5C};
        vt[3] = '{1'b0, 1'b0, 4'h3, 8'h3C, 8'hA5, 8'h5C};
        vt[4] = '{1'b0, 1'b1, 4'h3, 8'h00, 8'h3C, 8'h5C};
        vt[5] = '{1'b1, 1'b1, 4'hF, 8'h00, 8'h3C, 8'hFF};
        vt[6] = '{1'b0, 1'b1, 4'h1, 8'h00, 8'h11, 8'hFF};

        for (int i = 0; i < 16; i++) mem[i] = 8'(i * 17);
        mem[3] = 8'hA5;
        drive_a(1'b0, 1'b0, 1'b0, 4'h0, 8'h00);
        drive_a(1'b1, 1'b0, 1'b0, 4'h0, 8'h00);
        ba.slv_datard = 8'h00;
        bb.m0_req = 1'b0; bb.m0_rwn = 1'b1; bb.m0_addr = 4'h1; bb.m0_wdata = 8'h00;
        bb.m1_req = 1'b0; bb.m1_rwn = 1'b1; bb.m1_addr = 4'h2; bb.m1_wdata = 8'h00;
        bb.slv_datard = 8'h00;
        bc.m0_req = 1'b0; bc.m0_rwn = 1'b1; bc.m0_addr = 4'h7; bc.m0_wdata = 8'h00;
        bc.m1_req = 1'b0; bc.m1_rwn = 1'b1; bc.m1_addr = 4'h0; bc.m1_wdata = 8'h00;
        bc.slv_datard = 8'h00;

        tick(); tick(); tick();
        chk("rst_acks", {ba.m0_ack, ba.m1_ack}, 0);
        chk("rst_slv_ctl", {ba.slv_req, ba.slv_datawr_valid, ba.slv_rwn}, 0);
        chk("rst_slv_addr", ba.slv_addr, 0);
        chk("rst_slv_datawr", ba.slv_datawr, 0);
        chk("rst_rdata", {ba.m0_rdata, ba.m1_rdata}, 0);
        chk("rst_l3_outs", {bc.m0_ack, bc.m1_ack, bc.slv_req, bc.m0_rdata}, 0);
        reset = 1'b0;

        // Both masters hold requests: round-robin alternates, fixed priority starves m1.
        for (int i = 0; i < 4; i++) begin ga[i] = -1; gb[i] = -1; end
        na = 0; nb = 0;
        drive_a(1'b0, 1'b1, 1'b1, 4'h1, 8'h00);
        drive_a(1'b1, 1'b1, 1'b1, 4'h2, 8'h00);
        bb.m0_req = 1'b1; bb.m1_req = 1'b1;
        for (int c = 0; c < 60 && (na < 4 || nb < 4); c++) begin
            tick();
            if (na < 4 && (ba.m0_ack || ba.m1_ack)) begin
                ga[na] = ba.m1_ack ? 1 : 0;
                na++;
                if (na == 4) begin ba.m0_req = 1'b0; ba.m1_req = 1'b0; end
            end
            if (nb < 4 && (bb.m0_ack || bb.m1_ack)) begin
                gb[nb] = bb.m1_ack ? 1 : 0;
                nb++;
                if (nb == 4) begin bb.m0_req = 1'b0; bb.m1_req = 1'b0; end
            end
        end
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("rr_grant%0d", i), ga[i], i % 2);
            chk($sformatf("fp_grant%0d", i), gb[i], 0);
        end
        ba.m0_req = 1'b0; ba.m1_req = 1'b0; bb.m0_req = 1'b0; bb.m1_req = 1'b0;

        do_reset();
        for (int i = 0; i < 7; i++)
            run_txn($sformatf("vec%0d", i), vt[i].m, vt[i].rwn, vt[i].addr, vt[i].wd, vt[i].r0, vt[i].r1);

        // Reset during the WAIT of an m1 read abandons it.
        bad = 0;
        drive_a(1'b1, 1'b1, 1'b1, 4'h2, 8'h00);
        tick();
        chk("rstwait_issue", ba.slv_req, 1);
        bad += int'(ba.m0_ack) + int'(ba.m1_ack);
        tick();
        bad += int'(ba.m0_ack) + int'(ba.m1_ack);
        reset = 1'b1;
        tick();
        bad += int'(ba.m0_ack) + int'(ba.m1_ack);
        chk("rstwait_rdata", {ba.m0_rdata, ba.m1_rdata}, 0);
        chk("rstwait_slv", {ba.slv_req, ba.slv_datawr_valid, ba.slv_rwn, ba.slv_addr, ba.slv_datawr}, 0);
        reset = 1'b0;
        drive_a(1'b1, 1'b0, 1'b1, 4'h2, 8'h00);
        tick();
        bad += int'(ba.m0_ack) + int'(ba.m1_ack);
        tick();
        bad += int'(ba.m0_ack) + int'(ba.m1_ack) + int'(ba.slv_req);
        chk("rstwait_no_ack", bad, 0);
        run_txn("after_rst", 1'b0, 1'b1, 4'h2, 8'h00, 8'h22, 8'h00);

        // m0 drops its request right after being granted.
        drive_a(1'b0, 1'b1, 1'b1, 4'h4, 8'h00);
        tick();
        chk("drop_issue", ba.slv_req, 1);
        drive_a(1'b0, 1'b0, 1'b1, 4'h4, 8'h00);
        tack = -1; nack = 0; nreq = 0;
        for (int c = 2; c <= 12; c++) begin
            tick();
            if (ba.m0_ack) begin nack++; tack = c; end
            if (ba.slv_req) nreq++;
        end
        chk("drop_ack_cycle", tack, 3);
        chk("drop_ack_count", nack, 1);
        chk("drop_regrant", nreq, 0);
        chk("drop_rdata", ba.m0_rdata, 8'h44);

        // RD_LAT=3, m0 holds req for two back-to-back reads of a moving value.
        g = -1; a1 = -1; a2 = -1; nack = 0;
        bc.m0_req = 1'b1;
        for (int c = 0; c < 30 && nack < 2; c++) begin
            tick();
            if (bc.slv_req) g = ecount;
            if (bc.m0_ack) begin
                chk($sformatf("l3_rdata%0d", nack), bc.m0_rdata, 8'(g + 3));
                if (nack == 0) begin
                    a1 = ecount;
                    chk("l3_ack_latency", ecount - g, 4);
                end else begin
                    a2 = ecount;
                    bc.m0_req = 1'b0;
                end
                nack++;
            end
        end
        bc.m0_req = 1'b0;
        chk("l3_ack_spacing", a2 - a1, 6);

        // Randomized traffic against a transaction-level model of ba.
        do_reset();
        for (int i = 0; i < 16; i++) mmem[i] = mem[i];
        for (int m = 0; m < 2; m++) begin act[m] = 1'b0; exp_rd[m] = 8'h00; end
        next_eval = ecount + 1;
        txn_valid = 1'b0; last = 1'b1; tg = 0; tm = 1'b0; trwn = 1'b0;
        taddr = 4'h0; twd = 8'h00; exp_rdval = 8'h00;
        for (int c = 0; c < 1500; c++) begin
            tick();
            exp_req = txn_valid && (ecount == tg);
            is_ack  = txn_valid && (ecount == tg + 2);
            chk("rnd_slv_req", ba.slv_req, exp_req);
            if (exp_req) begin
                chk("rnd_addr", ba.slv_addr, taddr);
                chk("rnd_rwn", ba.slv_rwn, trwn);
                chk("rnd_wvalid", ba.slv_datawr_valid, !trwn);
                chk("rnd_wdata", ba.slv_datawr, twd);
            end
            if (is_ack && trwn) exp_rd[tm] = exp_rdval;
            chk("rnd_ack0", ba.m0_ack, is_ack && !tm);
            chk("rnd_ack1", ba.m1_ack, is_ack && tm);
            chk("rnd_rdata0", ba.m0_rdata, exp_rd[0]);
            chk("rnd_rdata1", ba.m1_rdata, exp_rd[1]);
            if (is_ack) begin
                act[tm] = 1'b0;
                txn_valid = 1'b0;
            end
            for (int m = 0; m < 2; m++) begin
                if (!act[m] && $urandom_range(99) < 35) begin
                    act[m]    = 1'b1;
                    f_rwn[m]  = 1'($urandom_range(1));
                    f_addr[m] = 4'($urandom_range(15));
                    f_wd[m]   = 8'($urandom_range(255));
                end
                drive_a(1'(m), act[m], f_rwn[m], f_addr[m], f_wd[m]);
            end
            if (!txn_valid && (ecount + 1 >= next_eval) && (act[0] || act[1])) begin
                if (act[0] && act[1]) w = !last;
                else                  w = act[1];
                tg = ecount + 1; tm = w; trwn = f_rwn[w]; taddr = f_addr[w]; twd = f_wd[w];
                if (trwn) exp_rdval = mmem[taddr];
                else      mmem[taddr] = twd;
                last = w;
                next_eval = tg + 4;
                txn_valid = 1'b1;
            end
        end
        drive_a(1'b0, 1'b0, 1'b0, 4'h0, 8'h00);
        drive_a(1'b1, 1'b0, 1'b0, 4'h0, 8'h00);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
